// File: rtl/w0rm_core_alu_pipe.sv
// W0RM integer ALU with valid/ready on both sides; single-cycle ops load the
// output register on acceptance, MUL/DIV/REM run on a bit-serial engine.
module w0rm_core_alu_pipe #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned USER_WIDTH    = 1,
  parameter int unsigned ENABLE_MULDIV = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            opcode,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic [3:0]            store_flags_mask,
  input  logic                  ext_bit_size,
  input  logic [USER_WIDTH-1:0] user_data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [USER_WIDTH-1:0] user_data_out,
  output logic                  flag_zero,
  output logic                  flag_negative,
  output logic                  flag_overflow,
  output logic                  flag_carry,
  output logic                  busy
);
  localparam int unsigned W   = DATA_WIDTH;
  localparam int unsigned SW  = $clog2(DATA_WIDTH);
  localparam int unsigned CW  = $clog2(DATA_WIDTH + 1);
  localparam int unsigned E8  = DATA_WIDTH - 8;
  localparam int unsigned E16 = DATA_WIDTH - 16;

  localparam logic [3:0] OP_AND = 4'h0, OP_OR  = 4'h1, OP_XOR = 4'h2, OP_NOT = 4'h3;
  localparam logic [3:0] OP_NEG = 4'h4, OP_MUL = 4'h5, OP_DIV = 4'h6, OP_REM = 4'h7;
  localparam logic [3:0] OP_ADD = 4'h8, OP_SUB = 4'h9, OP_SEX = 4'hA, OP_ZEX = 4'hB;
  localparam logic [3:0] OP_LSR = 4'hC, OP_LSL = 4'hD, OP_ASR = 4'hE, OP_MOV = 4'hF;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]            state_q, state_nx;
  logic                  run_q;
  logic [3:0]            op_q, mask_q;
  logic [W-1:0]          a_q, b_q, hi_q, lo_q, hi_nx, lo_nx;
  logic [USER_WIDTH-1:0] tag_q;
  logic [CW-1:0]         cnt_q;

  logic slot_free, accept, is_iter, load_sc, load_it, iter_done;

  // Single-cycle datapath
  logic [SW-1:0] amt;
  logic [W:0]    add_sum, sub_dif, lsl_ext, lsr_ext, asr_ext;
  logic [W-1:0]  neg_res, sex8, sex16, zex8, zex16, min_neg;
  logic          add_v, sub_v;
  logic [W-1:0]  sc_res;
  logic          sc_v, sc_c;

  assign amt     = data_b[SW-1:0];
  assign add_sum = {1'b0, data_a} + {1'b0, data_b};
  assign sub_dif = {1'b0, data_a} - {1'b0, data_b};
  assign lsl_ext = {1'b0, data_a} << amt;
  assign lsr_ext = {data_a, 1'b0} >> amt;
  assign asr_ext = (W+1)'($signed({data_a, 1'b0}) >>> amt);
  assign neg_res = W'(0) - data_a;
  assign min_neg = {1'b1, {(W-1){1'b0}}};
  assign sex8    = W'($signed(data_a << E8) >>> E8);
  assign sex16   = W'($signed(data_a << E16) >>> E16);
  assign zex8    = W'((data_a << E8) >> E8);
  assign zex16   = W'((data_a << E16) >> E16);
  assign add_v   = (data_a[W-1] == data_b[W-1]) && (add_sum[W-1] != data_a[W-1]);
  assign sub_v   = (data_a[W-1] != data_b[W-1]) && (sub_dif[W-1] != data_a[W-1]);

  always_comb begin
    sc_res = '0;
    sc_v   = 1'b0;
    sc_c   = 1'b0;
    case (opcode)
      OP_AND: sc_res = data_a & data_b;
      OP_OR:  sc_res = data_a | data_b;
      OP_XOR: sc_res = data_a ^ data_b;
      OP_NOT: sc_res = ~data_a;
      OP_NEG: begin sc_res = neg_res; sc_v = (data_a == min_neg); sc_c = (data_a != '0); end
      OP_ADD: begin sc_res = add_sum[W-1:0]; sc_c = add_sum[W]; sc_v = add_v; end
      OP_SUB: begin sc_res = sub_dif[W-1:0]; sc_c = sub_dif[W]; sc_v = sub_v; end
      OP_SEX: sc_res = ext_bit_size ? sex16 : sex8;
      OP_ZEX: sc_res = ext_bit_size ? zex16 : zex8;
      OP_LSR: begin sc_res = lsr_ext[W:1]; sc_c = lsr_ext[0]; end
      OP_LSL: begin sc_res = lsl_ext[W-1:0]; sc_c = lsl_ext[W]; end
      OP_ASR: begin sc_res = asr_ext[W:1]; sc_c = asr_ext[0]; end
      OP_MOV: sc_res = data_b;
      default: sc_v = 1'b1;  // MUL/DIV/REM with the engine stripped out
    endcase
  end

  // Bit-serial engine: {hi,lo} is the product for MUL, {remainder,quotient} for DIV/REM
  logic [W:0]   mul_sum;
  logic         div_ge;
  logic [W-1:0] div_sub;

  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
  assign div_ge  = {hi_q, lo_q[W-1]} >= {1'b0, b_q};
  assign div_sub = {hi_q[W-2:0], lo_q[W-1]} - b_q;

  always_comb begin
    hi_nx = hi_q;
    lo_nx = lo_q;
    if (op_q == OP_MUL) begin
      hi_nx = mul_sum[W:1];
      lo_nx = {mul_sum[0], lo_q[W-1:1]};
    end else if (div_ge) begin
      hi_nx = div_sub;
      lo_nx = {lo_q[W-2:0], 1'b1};
    end else begin
      hi_nx = {hi_q[W-2:0], lo_q[W-1]};
      lo_nx = {lo_q[W-2:0], 1'b0};
    end
  end

  logic         b_zero;
  logic [W-1:0] it_res;
  logic         it_v, it_c;

  assign b_zero = (b_q == '0);

  always_comb begin
    it_res = lo_q;
    it_v   = 1'b0;
    it_c   = 1'b0;
    case (op_q)
      OP_MUL:  it_c = |hi_q;
      OP_DIV:  begin it_v = b_zero; if (b_zero) it_res = '1; end
      default: begin it_v = b_zero; it_res = b_zero ? a_q : hi_q; end
    endcase
  end

  // Handshake and load control
  assign slot_free = ~out_valid | out_ready;
  assign in_ready  = run_q & (state_q == S_IDLE) & slot_free;
  assign busy      = (state_q != S_IDLE);
  assign accept    = in_valid & in_ready;
  assign is_iter   = (ENABLE_MULDIV != 0) &&
                     ((opcode == OP_MUL) || (opcode == OP_DIV) || (opcode == OP_REM));
  assign load_sc   = accept & ~is_iter;
  assign iter_done = (state_q == S_ITER) && (cnt_q == '0);
  assign load_it   = slot_free & (iter_done || (state_q == S_HOLD));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_nx;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_iter) state_nx = S_ITER;
      S_ITER:  if (cnt_q == '0) state_nx = slot_free ? S_IDLE : S_HOLD;
      S_HOLD:  if (slot_free) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q   <= '0;
      mask_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      tag_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
    end else if (accept && is_iter) begin
      op_q   <= opcode;
      mask_q <= store_flags_mask;
      a_q    <= data_a;
      b_q    <= data_b;
      tag_q  <= user_data_in;
      hi_q   <= '0;
      lo_q   <= (opcode == OP_MUL) ? data_b : data_a;
      cnt_q  <= CW'(DATA_WIDTH);
    end else if ((state_q == S_ITER) && (cnt_q != '0)) begin
      hi_q   <= hi_nx;
      lo_q   <= lo_nx;
      cnt_q  <= cnt_q - CW'(1);
    end
  end

  logic [W-1:0]          ld_res;
  logic [USER_WIDTH-1:0] ld_tag;
  logic [3:0]            ld_mask;
  logic                  ld_v, ld_c;

  assign ld_res  = load_it ? it_res : sc_res;
  assign ld_tag  = load_it ? tag_q  : user_data_in;
  assign ld_mask = load_it ? mask_q : store_flags_mask;
  assign ld_v    = load_it ? it_v   : sc_v;
  assign ld_c    = load_it ? it_c   : sc_c;

  // Output slot and architectural flags, written only when a result lands
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid     <= 1'b0;
      result        <= '0;
      user_data_out <= '0;
      flag_zero     <= 1'b0;
      flag_negative <= 1'b0;
      flag_overflow <= 1'b0;
      flag_carry    <= 1'b0;
    end else if (load_sc || load_it) begin
      out_valid     <= 1'b1;
      result        <= ld_res;
      user_data_out <= ld_tag;
      if (ld_mask[0]) flag_zero     <= (ld_res == '0);
      if (ld_mask[1]) flag_negative <= ld_res[W-1];
      if (ld_mask[2]) flag_overflow <= ld_v;
      if (ld_mask[3]) flag_carry    <= ld_c;
    end else if (out_ready) begin
      out_valid     <= 1'b0;
    end
  end

endmodule
